// File: rtl/pau_arbiter.sv
// pau_arbiter: round-robin sharing of one posit add/mul/div datapath between NREQ requesters
module pau_arbiter #(
    parameter int NREQ     = 2,
    parameter int N        = 32,
    parameter int MIN_WAIT = 3,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [N*NREQ-1:0] req_a,
    input  logic [N*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [N-1:0]      resp_data,
    output logic              resp_err,
    output logic              unit_start,
    output logic [1:0]        unit_op,
    output logic [N-1:0]      unit_a,
    output logic [N-1:0]      unit_b,
    input  logic              unit_done,
    input  logic [N-1:0]      unit_res_add,
    input  logic [N-1:0]      unit_res_mul,
    input  logic [N-1:0]      unit_res_div,
    output logic              busy
);
    localparam int IDW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           r_state, w_next;
    logic [IDW-1:0]   r_gnt, r_last, w_win_id, w_idx;
    logic             w_any, w_accept, w_release, w_done, w_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [N-1:0]     r_a, r_b, r_data, w_res;
    logic             r_err;

    assign w_done     = (r_state == BUSY) && unit_done && (r_cnt >= CNT_W'(MIN_WAIT));
    assign w_timeout  = r_cnt == CNT_W'(TIMEOUT);
    assign w_res      = (r_op == 2'b11) ? unit_res_div : (r_op == 2'b10) ? unit_res_mul : unit_res_add;
    assign unit_start = r_state == BUSY;
    assign busy       = r_state != IDLE;
    assign unit_op    = r_op;
    assign unit_a     = r_a;
    assign unit_b     = r_b;
    assign resp_data  = r_data;
    assign resp_err   = r_err;

    // first valid requester searching upward from the one served last
    always_comb begin
        w_any    = 1'b0;
        w_win_id = '0;
        w_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((int'(r_last) + k) % NREQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_win_id = w_idx;
            end
        end
    end

    // next state, grant strobe and response strobe
    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        resp_valid = '0;
        w_accept   = 1'b0;
        w_release  = 1'b0;
        case (r_state)
            IDLE: if (w_any) begin
                req_ready[w_win_id] = 1'b1;
                w_accept            = 1'b1;
                w_next              = BUSY;
            end
            BUSY: w_next = (w_done || w_timeout) ? RESP : BUSY;
            RESP: begin
                resp_valid[r_gnt] = 1'b1;
                if (resp_ready[r_gnt]) begin
                    w_release = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // operand capture, settle/timeout counter, result capture, rr pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt  <= '0;
            r_last <= IDW'(NREQ - 1);
            r_cnt  <= '0;
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt <= w_win_id;
                r_op  <= req_op[2*w_win_id +: 2];
                r_a   <= req_a[N*w_win_id +: N];
                r_b   <= req_b[N*w_win_id +: N];
                r_cnt <= '0;
            end
            if (r_state == BUSY) begin
                r_cnt <= w_timeout ? r_cnt : r_cnt + 1'b1;
                if (w_done) begin
                    r_data <= w_res;
                    r_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_data <= '0;
                    r_err  <= 1'b1;
                end
            end
            if (w_release) r_last <= r_gnt;
        end
    end
endmodule

// File: tb/tb_pau_arbiter.sv
// tb_pau_arbiter: scoreboard bench for the round-robin posit arbiter
module tb_pau_arbiter;
    localparam int NREQ = 2, N = 32, MIN_WAIT = 3, TIMEOUT = 15;
    localparam logic [N-1:0] ADD_V = 32'h48000000, MUL_V = 32'h50000000, DIV_V = 32'h38000000;

    logic              clk = 1'b0, rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0, req_ready, resp_valid, resp_ready = '1;
    logic [2*NREQ-1:0] req_op = '0;
    logic [N*NREQ-1:0] req_a = '0, req_b = '0;
    logic [N-1:0]      resp_data, unit_a, unit_b;
    logic              resp_err, unit_start, unit_done, busy;
    logic [1:0]        unit_op;

    typedef struct {
        int         id;
        logic [N-1:0] data;
        logic       err;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    int   n_chk = 0, n_err = 0, cyc = 0, done_at = 3, bcnt = 0, m_last = NREQ - 1;
    int   w, eff;
    bit   prev_rv = 1'b0;
    exp_t e;
    logic [1:0] op;

    pau_arbiter #(.NREQ(NREQ), .N(N), .MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
        .unit_done(unit_done), .unit_res_add(ADD_V), .unit_res_mul(MUL_V), .unit_res_div(DIV_V),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // posit unit model: done once it has seen start for done_at cycles (never when done_at < 0)
    assign unit_done = unit_start && done_at >= 0 && bcnt >= done_at;
    always @(posedge clk or negedge rst) begin
        if (!rst) bcnt <= 0;
        else      bcnt <= unit_start ? bcnt + 1 : 0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int winner(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // scoreboard: push expectation on grant, compare on every response cycle, pop on handshake
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            sb.delete();
            m_last  = NREQ - 1;
            prev_rv = 1'b0;
        end else begin
            if (req_ready != '0) begin
                w = winner(req_valid, m_last);
                chk("grant", 64'(req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
                if (w >= 0) begin
                    op    = req_op[2*w +: 2];
                    eff   = (done_at < 0 || done_at > TIMEOUT) ? -1 : (done_at > MIN_WAIT ? done_at : MIN_WAIT);
                    e.id  = w;
                    e.err = eff < 0;
                    e.data = e.err ? '0 : (op == 2'b11) ? DIV_V : (op == 2'b10) ? MUL_V : ADD_V;
                    e.lat = e.err ? TIMEOUT + 2 : eff + 2;
                    e.acc = cyc;
                    sb.push_back(e);
                    glog.push_back(w);
                end
            end
            if (resp_valid != '0) begin
                if (sb.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'd0);
                else begin
                    e = sb[0];
                    if (!prev_rv) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("resp_valid", 64'(resp_valid), 64'd1 << e.id);
                    chk("resp_data", 64'(resp_data), 64'(e.data));
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                    if (resp_ready[e.id]) begin
                        m_last = e.id;
                        void'(sb.pop_front());
                    end
                end
            end
            prev_rv = resp_valid != '0;
        end
    end

    task automatic issue(input int id, input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        @(posedge clk);
        #1;
        req_op[2*id +: 2] = o;
        req_a[N*id +: N]  = a;
        req_b[N*id +: N]  = b;
        req_valid[id]     = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready[id]) break;
        end
        chk("accept", 64'(req_ready[id]), 64'd1);
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && (sb.size() != 0 || busy); i++) @(negedge clk);
        chk("drain", 64'(sb.size() == 0 && !busy), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start", 64'(unit_start), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_unit_op", 64'(unit_op), 64'd0);
        chk("rst_unit_ab", 64'({unit_a, unit_b}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // single add on requester 0, done at cnt=3
        done_at = 3;
        issue(0, 2'b00, 32'h40000000, 32'h40000000);
        chk("busy_start", 64'(unit_start), 64'd1);
        chk("busy_unit_a", 64'(unit_a), 64'h40000000);
        chk("busy_unit_op", 64'(unit_op), 64'd0);
        wait_idle();

        // timeout on requester 1 mul, unit never finishes
        done_at = -1;
        issue(1, 2'b10, 32'h12345678, 32'h9abcdef0);
        wait_idle();

        // fairness: both held valid for four grants
        done_at = 3;
        @(posedge clk);
        #1;
        req_op    = 4'b0100;
        req_a     = {32'h40000000, 32'h3c000000};
        req_b     = {32'h38000000, 32'h44000000};
        glog.delete();
        req_valid = 2'b11;
        for (int i = 0; i < 100 && glog.size() < 4; i++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_idle();
        chk("rr_count", 64'(glog.size() >= 4), 64'd1);
        for (int k = 0; k < 4 && k < glog.size(); k++) chk("rr_order", 64'(glog[k]), 64'(k % 2));

        // early done held from the first busy cycle is only honoured at cnt=MIN_WAIT
        done_at = 0;
        issue(0, 2'b11, 32'h50000000, 32'h48000000);
        wait_idle();

        // done exactly at the timeout count wins over the timeout
        done_at = TIMEOUT;
        issue(1, 2'b00, 32'h40000000, 32'h40000000);
        wait_idle();

        // response backpressure on requester 0 with requester 1 waiting
        done_at = 3;
        resp_ready = 2'b10;
        issue(0, 2'b00, 32'h40000000, 32'h40000000);
        req_op[3:2] = 2'b10;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 40 && !resp_valid[0]; i++) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_start", 64'(unit_start), 64'd0);
            if (k < 5) @(negedge clk);
        end
        @(posedge clk);
        #1 resp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_hs_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("bp_next_grant", 64'(req_ready), 64'd2);
        @(posedge clk);
        #1;
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        wait_idle();

        // reset in the middle of BUSY at cnt=2
        done_at = -1;
        issue(0, 2'b01, 32'h40000000, 32'h40000000);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_start", 64'(unit_start), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        done_at   = 3;
        req_op    = 4'b1000;
        req_valid = 2'b11;
        for (int i = 0; i < 10 && req_ready == '0; i++) @(negedge clk);
        chk("prio_after_rst", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
